sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, data bits per entry.
- FIFO_DEPTH, 8, entries; power of two, at least 2.
- PTR_WIDTH, 3, log2(FIFO_DEPTH).
- AFULL_TH, 6, almost_full threshold, 1..FIFO_DEPTH.
- AEMPTY_TH, 1, almost_empty threshold, 0..FIFO_DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_valid, in, 1, write request.
- wr_data, in, DATA_WIDTH, write data.
- wr_ready, out, 1, equals !full.
- rd_ready, in, 1, read request / consumer ready.
- rd_valid, out, 1, rd_data valid.
- rd_data, out, DATA_WIDTH, read data.
- full, out, 1, count == FIFO_DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AFULL_TH.
- almost_empty, out, 1, count <= AEMPTY_TH.
- count, out, PTR_WIDTH+1, current occupancy, 0..FIFO_DEPTH.
- flush, in, 1, synchronous discard of all contents.
- overflow, out, 1, sticky: a write was attempted while full.
- underflow, out, 1, sticky: a read was attempted while empty.
- clr_err, in, 1, clears overflow and underflow.

Function
REQ-003 Pointers shall be PTR_WIDTH+1 bits wide: the low PTR_WIDTH bits address storage and the MSB is the wrap bit; pointers wrap modulo 2*FIFO_DEPTH.
REQ-004 full, empty, almost_full, almost_empty and wr_ready shall decode combinationally from registered pointers and count only, with no path from wr_valid or rd_ready.
REQ-005 w_en = wr_valid && !full && !flush; on w_en, wr_data is written at wptr and wptr increments by 1.
REQ-006 r_en = rd_ready && !empty && !flush; on r_en, rptr increments by 1.
REQ-007 count shall update as follows: +1 on w_en only, -1 on r_en only, unchanged when both or neither occur.
REQ-008 Write and read in the same cycle shall both complete whenever neither is individually blocked (not full, not empty).
REQ-009 No pass-through: a write into an empty FIFO shall not satisfy a read in the same cycle, and a read from a full FIFO shall not free space for a same-cycle write.
REQ-010 FWFT=0: rd_data shall be registered from mem[rptr] on r_en; rd_valid shall be 1 in the cycle after r_en and 0 otherwise; rd_data shall hold its last value when not reading.
REQ-011 FWFT=1: rd_valid = !empty; rd_data = mem[rptr] combinationally; a pop occurs when rd_valid && rd_ready; read latency is 0.
REQ-012 flush=1 shall set wptr, rptr and count to 0 next cycle, force rd_valid to 0 next cycle, and take priority over same-cycle write and read; storage contents are not cleared.
REQ-013 overflow shall set on wr_valid && full && !flush; underflow shall set on rd_ready && empty && !flush.
REQ-014 clr_err shall clear both error flags next cycle; a same-cycle set wins over clear; flush does not affect the error flags.
REQ-015 Thresholds outside their legal ranges are illegal configurations; behaviour in those cases is unspecified.

Reset
REQ-016 When rst=1 at a clock edge, the following shall all be 0 next cycle: wptr, rptr, count, rd_valid, overflow, underflow.
REQ-017 Reset values of the outputs shall be:
- rd_data = 0 (FWFT=0 register);
- empty = 1, almost_empty = 1;
- full = 0, almost_full = 0;
- wr_ready = 1.
REQ-018 rst shall take priority over flush, writes, reads and clr_err, including in the middle of a burst.

Verification
REQ-019 Fill and drain. Defaults; write 8 words 0x01..0x08 with no reads.
- Required: full=1, count=8, almost_full first asserted at count=6.
- Then read 8 words. Required: data returned 0x01..0x08 in order, each with rd_valid one cycle after its rd_ready, and empty=1 at the end.
REQ-020 Overflow. Assert wr_valid while full.
- Required: count stays 8, storage is unchanged, overflow=1 and stays 1 until clr_err.
- Underflow. Assert rd_ready while empty. Required: underflow=1.
REQ-021 Simultaneous access.
- At count=4, assert wr_valid and rd_ready together for 20 cycles. Required: count stays 4, pointers wrap past 15, and data order is preserved.
- At count=0, assert both. Required: only the write completes, count=1 and rd_valid=0.
REQ-022 FWFT=1.
- Write 0xA5 into an empty FIFO. Required: rd_valid=1 and rd_data=0xA5 in the next cycle with no rd_ready.
- Pop it. Required: empty=1 next cycle.
REQ-023 Flush and reset.
- At count=5, assert flush together with wr_valid. Required: count=0, empty=1, rd_valid=0 next cycle, and the write is discarded.
- Pulse rst mid-burst. Required: all REQ-017 values next cycle.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy and threshold flags, sticky error flags,
// synchronous flush, and a registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  input  logic                  flush,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_TH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic [PTR_WIDTH:0]    cnt;
  logic                  w_en;
  logic                  r_en;
  logic                  ovf_set;
  logic                  udf_set;

  // Flags decode from registered state only; no request input reaches them.
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AFULL_C);
  assign almost_empty = (cnt <= AEMPTY_C);
  assign wr_ready     = !full;
  assign count        = cnt;

  assign w_en    = wr_valid && !full  && !flush;
  assign r_en    = rd_ready && !empty && !flush;
  assign ovf_set = wr_valid && full  && !flush;
  assign udf_set = rd_ready && empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (w_en) wptr <= wptr + 1'b1;
      if (r_en) rptr <= rptr + 1'b1;
      case ({w_en, r_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A same-cycle set outranks clr_err so no error event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set || (overflow  && !clr_err);
      underflow <= udf_set || (underflow && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (w_en && !rst) mem[wptr[PTR_WIDTH-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_valid = !empty;
      assign rd_data  = mem[rptr[PTR_WIDTH-1:0]];
    end else begin : g_reg
      logic                  rd_valid_p1;
      logic [DATA_WIDTH-1:0] rd_data_p1;

      // p1: registered read port, one cycle after the pop
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_p1 <= 1'b0;
          rd_data_p1  <= '0;
        end else begin
          rd_valid_p1 <= r_en;
          if (r_en) rd_data_p1 <= mem[rptr[PTR_WIDTH-1:0]];
        end
      end

      assign rd_valid = rd_valid_p1;
      assign rd_data  = rd_data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table plus queue scoreboard
// on a registered-read instance, and directed checks on an FWFT instance.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, rd_ready, flush, clr_err;
  logic [7:0] wr_data;
  logic       wr_ready, rd_valid, full, empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [7:0] rd_data;
  logic [3:0] count;

  logic       f_wr_valid, f_rd_ready, f_flush, f_clr_err;
  logic [7:0] f_wr_data;
  logic       f_wr_ready, f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [7:0] f_rd_data;
  logic [3:0] f_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb[$];
  logic [7:0] exp_rd;
  logic       exp_rv;
  logic       m_ovf;
  logic       m_udf;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       fl;
    logic       ce;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[21];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(8), .FIFO_DEPTH(8), .PTR_WIDTH(3),
    .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .flush(flush), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  sync_fifo_param #(
    .DATA_WIDTH(8), .FIFO_DEPTH(8), .PTR_WIDTH(3),
    .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)
  ) dut_f (
    .clk(clk), .rst(rst),
    .wr_valid(f_wr_valid), .wr_data(f_wr_data), .wr_ready(f_wr_ready),
    .rd_ready(f_rd_ready), .rd_valid(f_rd_valid), .rd_data(f_rd_data),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .flush(f_flush), .overflow(f_overflow), .underflow(f_underflow),
    .clr_err(f_clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock on the registered-read instance; the queue model predicts every output.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr,
                     input logic fl, input logic ce);
    logic fm, em, w, r;
    fm = (sb.size() == 8);
    em = (sb.size() == 0);
    w  = wv && !fm && !fl;
    r  = rr && !em && !fl;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; clr_err = ce;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (r) exp_rd = sb.pop_front();
      if (w) sb.push_back(wd);
    end
    m_ovf  = (wv && fm && !fl) || (m_ovf && !ce);
    m_udf  = (rr && em && !fl) || (m_udf && !ce);
    exp_rv = r;
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; clr_err = 1'b0;
    chk("count",        count,        sb.size());
    chk("full",         full,         sb.size() == 8);
    chk("empty",        empty,        sb.size() == 0);
    chk("almost_full",  almost_full,  sb.size() >= 6);
    chk("almost_empty", almost_empty, sb.size() <= 1);
    chk("wr_ready",     wr_ready,     sb.size() != 8);
    chk("rd_valid",     rd_valid,     exp_rv);
    chk("rd_data",      rd_data,      exp_rd);
    chk("overflow",     overflow,     m_ovf);
    chk("underflow",    underflow,    m_udf);
  endtask

  // Reset while every other control input is active; it must win over all of them.
  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b1; wr_data = 8'hC3; rd_ready = 1'b1; flush = 1'b1; clr_err = 1'b0;
    f_wr_valid = 1'b1; f_wr_data = 8'hC3; f_rd_ready = 1'b1; f_flush = 1'b0; f_clr_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_count",        count,        0);
    chk("rst_empty",        empty,        1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full",         full,         0);
    chk("rst_almost_full",  almost_full,  0);
    chk("rst_wr_ready",     wr_ready,     1);
    chk("rst_rd_valid",     rd_valid,     0);
    chk("rst_rd_data",      rd_data,      0);
    chk("rst_overflow",     overflow,     0);
    chk("rst_underflow",    underflow,    0);
    chk("rst_f_rd_valid",   f_rd_valid,   0);
    chk("rst_f_count",      f_count,      0);
    rst = 1'b0;
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    f_wr_valid = 1'b0; f_rd_ready = 1'b0;
    sb.delete();
    exp_rd = 8'h00; exp_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, i + 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[11 + i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7 - i, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

    rst = 1'b1;
    do_reset();

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl, vecs[i].ce);
      chk($sformatf("vec%0d_count", i),     count,     vecs[i].exp_cnt);
      chk($sformatf("vec%0d_overflow", i),  overflow,  vecs[i].exp_ovf);
      chk($sformatf("vec%0d_underflow", i), underflow, vecs[i].exp_udf);
    end

    // Steady simultaneous access at count 4, pointers wrapping
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    chk("simul_count", count, 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("simul_last_data", rd_data, 8'h33);

    // Both requests on an empty FIFO: only the write lands
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("both_empty_count",     count,     1);
    chk("both_empty_rd_valid",  rd_valid,  0);
    chk("both_empty_underflow", underflow, 1);

    // Flush at count 5 beats the same-cycle write and read
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", count, 5);
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("flush_count",    count,    0);
    chk("flush_empty",    empty,    1);
    chk("flush_rd_valid", rd_valid, 0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_flush_data", rd_data, 8'h77);

    // Reset in the middle of a write burst with an error flag set
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    do_reset();

    // First-word-fall-through instance
    f_wr_valid = 1'b1; f_wr_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    f_wr_valid = 1'b0;
    chk("fwft_rd_valid", f_rd_valid, 1);
    chk("fwft_rd_data",  f_rd_data,  8'hA5);
    chk("fwft_count",    f_count,    1);
    f_wr_valid = 1'b1; f_wr_data = 8'h3C;
    @(posedge clk); @(negedge clk);
    f_wr_valid = 1'b0;
    chk("fwft_head_held", f_rd_data, 8'hA5);
    chk("fwft_count2",    f_count,   2);
    f_rd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    f_rd_ready = 1'b0;
    chk("fwft_pop_data",     f_rd_data,  8'h3C);
    chk("fwft_pop_rd_valid", f_rd_valid, 1);
    f_rd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    f_rd_ready = 1'b0;
    chk("fwft_empty",       f_empty,     1);
    chk("fwft_rd_valid_lo", f_rd_valid,  0);
    chk("fwft_underflow",   f_underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
